// File: rtl/mesi_line_ctrl.sv
// MESI state holder for NUM_LINES directly indexed lines, with a CPU request port, a bus port and snoop response.
// state | meaning: IDLE = accepting CPU requests; REQ = bus_req held for grant; WAIT = bus owned, waiting for bus_done
module mesi_line_ctrl #(
    parameter int NUM_LINES  = 8,
    parameter int IDX_W      = $clog2(NUM_LINES),
    parameter bit UPGRADE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_valid,
    input  logic [1:0]       cpu_op,
    input  logic [IDX_W-1:0] cpu_idx,
    output logic             cpu_ready,
    output logic             cpu_resp_valid,
    output logic             cpu_resp_hit,
    output logic             bus_req,
    output logic [1:0]       bus_op,
    output logic [IDX_W-1:0] bus_idx,
    input  logic             bus_gnt,
    input  logic             bus_done,
    input  logic             bus_shared,
    input  logic             snp_valid,
    input  logic [1:0]       snp_op,
    input  logic [IDX_W-1:0] snp_idx,
    output logic             snp_share,
    output logic             snp_flush,
    input  logic [IDX_W-1:0] dbg_idx,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {INVALID = 2'b00, SHARED = 2'b01, EXCLUSIVE = 2'b10, MODIFIED = 2'b11} CacheState;
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT = 2'b10} CtrlState;

    localparam logic [1:0] OP_GETS = 2'b00, OP_GETX = 2'b01, OP_INV = 2'b10, OP_PUTX = 2'b11;
    localparam logic [1:0] CPU_WRITE = 2'b01, CPU_EVICT = 2'b10;

    CacheState lineState [NUM_LINES];
    CtrlState  ctrlState;

    CacheState cpuLine, snpLine, snpNext, hitNext;
    logic      accept, isMiss, snpActive, snpOnPending, raceUpgrade, raceCancel;
    logic [1:0] missOp;

    assign cpuLine   = lineState[cpu_idx];
    assign snpLine   = lineState[snp_idx];
    assign dbg_state = lineState[dbg_idx];
    assign cpu_ready = (ctrlState == IDLE) && !(snp_valid && snp_idx == cpu_idx);
    assign accept    = cpu_valid && cpu_ready;

    assign snpActive    = snp_valid && snp_op != OP_PUTX;
    assign snpNext      = (snp_op == OP_GETS && snpLine != INVALID) ? SHARED : INVALID;
    assign snpOnPending = snpActive && ctrlState == REQ && snp_idx == bus_idx;
    assign raceUpgrade  = snpOnPending && bus_op == OP_INV && (snp_op == OP_GETX || snp_op == OP_INV);
    assign raceCancel   = snpOnPending && bus_op == OP_PUTX && (snp_op == OP_GETS || snp_op == OP_GETX);

    always_comb begin
        isMiss  = 1'b0;
        missOp  = OP_GETS;
        hitNext = cpuLine;
        case (cpu_op)
            CPU_WRITE: begin
                case (cpuLine)
                    MODIFIED, EXCLUSIVE: hitNext = MODIFIED;
                    SHARED: begin
                        isMiss = 1'b1;
                        missOp = UPGRADE_EN ? OP_INV : OP_GETX;
                    end
                    default: begin
                        isMiss = 1'b1;
                        missOp = OP_GETX;
                    end
                endcase
            end
            CPU_EVICT: begin
                if (cpuLine == MODIFIED) begin
                    isMiss = 1'b1;
                    missOp = OP_PUTX;
                end else begin
                    hitNext = INVALID;
                end
            end
            default: begin
                if (cpuLine == INVALID) begin
                    isMiss = 1'b1;
                    missOp = OP_GETS;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) lineState[i] <= INVALID;
            ctrlState      <= IDLE;
            cpu_resp_valid <= 1'b0;
            cpu_resp_hit   <= 1'b0;
            bus_req        <= 1'b0;
            bus_op         <= OP_GETS;
            bus_idx        <= '0;
            snp_share      <= 1'b0;
            snp_flush      <= 1'b0;
        end else begin
            cpu_resp_valid <= 1'b0;
            cpu_resp_hit   <= 1'b0;
            snp_share      <= snpActive && snpLine != INVALID;
            snp_flush      <= snpActive && snpLine == MODIFIED && (snp_op == OP_GETS || snp_op == OP_GETX);
            if (snpActive) lineState[snp_idx] <= snpNext;

            case (ctrlState)
                IDLE: begin
                    if (accept) begin
                        if (isMiss) begin
                            ctrlState <= REQ;
                            bus_req   <= 1'b1;
                            bus_op    <= missOp;
                            bus_idx   <= cpu_idx;
                        end else begin
                            lineState[cpu_idx] <= hitNext;
                            cpu_resp_valid     <= 1'b1;
                            cpu_resp_hit       <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // The snooper's flush already wrote the dirty line back, so the PUTX is redundant.
                    if (raceCancel) begin
                        ctrlState      <= IDLE;
                        bus_req        <= 1'b0;
                        cpu_resp_valid <= 1'b1;
                    end else begin
                        if (raceUpgrade) bus_op <= OP_GETX;
                        if (bus_gnt) begin
                            ctrlState <= WAIT;
                            bus_req   <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (bus_done) begin
                        ctrlState      <= IDLE;
                        cpu_resp_valid <= 1'b1;
                        case (bus_op)
                            OP_GETS: lineState[bus_idx] <= bus_shared ? SHARED : EXCLUSIVE;
                            OP_PUTX: lineState[bus_idx] <= INVALID;
                            default: lineState[bus_idx] <= MODIFIED;
                        endcase
                    end
                end
                default: ctrlState <= IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!reset)
            assert (!(ctrlState == WAIT && snpActive && snp_idx == bus_idx))
            else $error("snoop to owned line %0d while bus transaction in flight", bus_idx);
    end
endmodule

// File: tb/tb_mesi_line_ctrl.sv
// Directed bench for mesi_line_ctrl: one instance with upgrade enabled, one without, sharing all inputs.
module tb_mesi_line_ctrl;
    localparam int N = 8;
    localparam int W = 3;
    localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11;
    localparam logic [1:0] GETS = 2'b00, GETX = 2'b01, INV = 2'b10, PUTX = 2'b11;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, EV = 2'b10;

    logic clk = 1'b0;
    logic reset;
    logic cpuValid, busGnt, busDone, busShared, snpValid;
    logic [1:0] cpuOp, snpOp;
    logic [W-1:0] cpuIdx, snpIdx, dbgIdx;

    logic cpuReadyA, respValidA, respHitA, busReqA, snpShareA, snpFlushA;
    logic [1:0] busOpA, dbgStateA;
    logic [W-1:0] busIdxA;
    logic cpuReadyB, respValidB, respHitB, busReqB, snpShareB, snpFlushB;
    logic [1:0] busOpB, dbgStateB;
    logic [W-1:0] busIdxB;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mesi_line_ctrl #(.NUM_LINES(N), .UPGRADE_EN(1'b1)) dutA (
        .clk(clk), .reset(reset),
        .cpu_valid(cpuValid), .cpu_op(cpuOp), .cpu_idx(cpuIdx), .cpu_ready(cpuReadyA),
        .cpu_resp_valid(respValidA), .cpu_resp_hit(respHitA),
        .bus_req(busReqA), .bus_op(busOpA), .bus_idx(busIdxA),
        .bus_gnt(busGnt), .bus_done(busDone), .bus_shared(busShared),
        .snp_valid(snpValid), .snp_op(snpOp), .snp_idx(snpIdx),
        .snp_share(snpShareA), .snp_flush(snpFlushA),
        .dbg_idx(dbgIdx), .dbg_state(dbgStateA)
    );

    mesi_line_ctrl #(.NUM_LINES(N), .UPGRADE_EN(1'b0)) dutB (
        .clk(clk), .reset(reset),
        .cpu_valid(cpuValid), .cpu_op(cpuOp), .cpu_idx(cpuIdx), .cpu_ready(cpuReadyB),
        .cpu_resp_valid(respValidB), .cpu_resp_hit(respHitB),
        .bus_req(busReqB), .bus_op(busOpB), .bus_idx(busIdxB),
        .bus_gnt(busGnt), .bus_done(busDone), .bus_shared(busShared),
        .snp_valid(snpValid), .snp_op(snpOp), .snp_idx(snpIdx),
        .snp_share(snpShareB), .snp_flush(snpFlushB),
        .dbg_idx(dbgIdx), .dbg_state(dbgStateB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpuIssue(input logic [1:0] op, input logic [W-1:0] idx);
        cpuValid = 1'b1; cpuOp = op; cpuIdx = idx;
        tick();
        cpuValid = 1'b0;
    endtask

    task automatic grantAndDone(input logic shared);
        busGnt = 1'b1;
        tick();
        busGnt = 1'b0;
        busDone = 1'b1; busShared = shared;
        tick();
        busDone = 1'b0; busShared = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (busReqA !== 1'b0 || respValidA !== 1'b0 || snpShareA !== 1'b0 || snpFlushA !== 1'b0) begin
            failures++; $display("FAIL reset_outputs got req=%b rv=%b sh=%b fl=%b exp all 0", busReqA, respValidA, snpShareA, snpFlushA);
        end
        reset = 1'b0;
        dbgIdx = 3'd3; #1;
        checks++; if (dbgStateA !== ST_I) begin failures++; $display("FAIL reset_dbg got=%b exp=%b", dbgStateA, ST_I); end
        checks++; if (cpuReadyA !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cpuReadyA); end
    endtask

    task automatic test_read_miss_write_hit();
        cpuIssue(RD, 3'd3);
        checks++; if (busReqA !== 1'b1 || busOpA !== GETS || busIdxA !== 3'd3) begin
            failures++; $display("FAIL read_miss_req got req=%b op=%b idx=%0d exp req=1 op=00 idx=3", busReqA, busOpA, busIdxA);
        end
        checks++; if (cpuReadyA !== 1'b0) begin failures++; $display("FAIL read_miss_busy_ready got=%b exp=0", cpuReadyA); end
        busGnt = 1'b1; tick(); busGnt = 1'b0;
        checks++; if (busReqA !== 1'b0) begin failures++; $display("FAIL read_miss_req_drop got=%b exp=0", busReqA); end
        busDone = 1'b1; tick(); busDone = 1'b0;
        dbgIdx = 3'd3; #1;
        checks++; if (respValidA !== 1'b1 || respHitA !== 1'b0) begin
            failures++; $display("FAIL read_miss_resp got v=%b hit=%b exp v=1 hit=0", respValidA, respHitA);
        end
        checks++; if (dbgStateA !== ST_E) begin failures++; $display("FAIL read_miss_state got=%b exp=%b", dbgStateA, ST_E); end
        cpuIssue(WR, 3'd3);
        checks++; if (respValidA !== 1'b1 || respHitA !== 1'b1 || busReqA !== 1'b0) begin
            failures++; $display("FAIL write_hit_resp got v=%b hit=%b req=%b exp 1 1 0", respValidA, respHitA, busReqA);
        end
        checks++; if (dbgStateA !== ST_M) begin failures++; $display("FAIL write_hit_state got=%b exp=%b", dbgStateA, ST_M); end
        tick();
        checks++; if (respValidA !== 1'b0) begin failures++; $display("FAIL write_hit_pulse got=%b exp=0", respValidA); end
    endtask

    task automatic test_snoop();
        cpuIssue(WR, 3'd5);
        checks++; if (busOpA !== GETX) begin failures++; $display("FAIL snoop_setup_op got=%b exp=%b", busOpA, GETX); end
        grantAndDone(1'b0);
        snpValid = 1'b1; snpOp = GETS; snpIdx = 3'd5;
        tick();
        dbgIdx = 3'd5; #1;
        checks++; if (snpFlushA !== 1'b1 || snpShareA !== 1'b1) begin
            failures++; $display("FAIL snoop_gets_m got fl=%b sh=%b exp 1 1", snpFlushA, snpShareA);
        end
        checks++; if (dbgStateA !== ST_S) begin failures++; $display("FAIL snoop_gets_state got=%b exp=%b", dbgStateA, ST_S); end
        snpOp = GETX;
        tick();
        snpValid = 1'b0;
        checks++; if (snpFlushA !== 1'b0 || snpShareA !== 1'b1) begin
            failures++; $display("FAIL snoop_getx_s got fl=%b sh=%b exp 0 1", snpFlushA, snpShareA);
        end
        checks++; if (dbgStateA !== ST_I) begin failures++; $display("FAIL snoop_getx_state got=%b exp=%b", dbgStateA, ST_I); end
        tick();
        checks++; if (snpShareA !== 1'b0) begin failures++; $display("FAIL snoop_idle_share got=%b exp=0", snpShareA); end
    endtask

    task automatic test_upgrade();
        cpuIssue(RD, 3'd2);
        grantAndDone(1'b1);
        dbgIdx = 3'd2; #1;
        checks++; if (dbgStateA !== ST_S || dbgStateB !== ST_S) begin
            failures++; $display("FAIL upgrade_setup got a=%b b=%b exp %b", dbgStateA, dbgStateB, ST_S);
        end
        cpuIssue(WR, 3'd2);
        checks++; if (busOpA !== INV) begin failures++; $display("FAIL upgrade_inv got=%b exp=%b", busOpA, INV); end
        checks++; if (busOpB !== GETX || busReqB !== 1'b1) begin
            failures++; $display("FAIL noupgrade_getx got op=%b req=%b exp op=%b req=1", busOpB, busReqB, GETX);
        end
        snpValid = 1'b1; snpOp = INV; snpIdx = 3'd2;
        tick();
        snpValid = 1'b0;
        checks++; if (busOpA !== GETX || busReqA !== 1'b1) begin
            failures++; $display("FAIL upgrade_race_convert got op=%b req=%b exp op=%b req=1", busOpA, busReqA, GETX);
        end
        checks++; if (dbgStateA !== ST_I) begin failures++; $display("FAIL upgrade_race_state got=%b exp=%b", dbgStateA, ST_I); end
        grantAndDone(1'b0);
        checks++; if (dbgStateA !== ST_M || dbgStateB !== ST_M) begin
            failures++; $display("FAIL upgrade_final got a=%b b=%b exp %b", dbgStateA, dbgStateB, ST_M);
        end
        checks++; if (respValidA !== 1'b1 || respHitA !== 1'b0) begin
            failures++; $display("FAIL upgrade_resp got v=%b hit=%b exp 1 0", respValidA, respHitA);
        end
    endtask

    task automatic test_evict_race();
        cpuIssue(WR, 3'd7);
        grantAndDone(1'b0);
        cpuIssue(EV, 3'd7);
        checks++; if (busOpA !== PUTX || busReqA !== 1'b1 || busIdxA !== 3'd7) begin
            failures++; $display("FAIL evict_putx got op=%b req=%b idx=%0d exp op=11 req=1 idx=7", busOpA, busReqA, busIdxA);
        end
        snpValid = 1'b1; snpOp = GETX; snpIdx = 3'd7;
        tick();
        snpValid = 1'b0;
        dbgIdx = 3'd7; #1;
        checks++; if (snpFlushA !== 1'b1 || busReqA !== 1'b0) begin
            failures++; $display("FAIL evict_race_cancel got fl=%b req=%b exp fl=1 req=0", snpFlushA, busReqA);
        end
        checks++; if (respValidA !== 1'b1 || respHitA !== 1'b0 || dbgStateA !== ST_I) begin
            failures++; $display("FAIL evict_race_resp got v=%b hit=%b st=%b exp v=1 hit=0 st=00", respValidA, respHitA, dbgStateA);
        end
        checks++; if (cpuReadyA !== 1'b1) begin failures++; $display("FAIL evict_race_idle got=%b exp=1", cpuReadyA); end
    endtask

    task automatic test_ready_and_reset();
        snpValid = 1'b1; snpOp = GETS; snpIdx = 3'd1;
        cpuValid = 1'b1; cpuOp = RD; cpuIdx = 3'd1;
        #1;
        checks++; if (cpuReadyA !== 1'b0) begin failures++; $display("FAIL ready_conflict got=%b exp=0", cpuReadyA); end
        tick();
        checks++; if (busReqA !== 1'b0 || respValidA !== 1'b0) begin
            failures++; $display("FAIL ready_conflict_noaccept got req=%b rv=%b exp 0 0", busReqA, respValidA);
        end
        cpuIdx = 3'd4; #1;
        checks++; if (cpuReadyA !== 1'b1) begin failures++; $display("FAIL ready_other_idx got=%b exp=1", cpuReadyA); end
        tick();
        cpuValid = 1'b0; snpValid = 1'b0;
        checks++; if (busReqA !== 1'b1 || busIdxA !== 3'd4 || busOpA !== GETS) begin
            failures++; $display("FAIL ready_accept got req=%b idx=%0d op=%b exp req=1 idx=4 op=00", busReqA, busIdxA, busOpA);
        end
        busGnt = 1'b1; tick(); busGnt = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (busReqA !== 1'b0 || respValidA !== 1'b0) begin
            failures++; $display("FAIL reset_wait_outputs got req=%b rv=%b exp 0 0", busReqA, respValidA);
        end
        for (int i = 0; i < N; i++) begin
            dbgIdx = W'(i); #1;
            checks++; if (dbgStateA !== ST_I) begin failures++; $display("FAIL reset_wait_line%0d got=%b exp=%b", i, dbgStateA, ST_I); end
        end
        busDone = 1'b1; tick(); busDone = 1'b0;
        dbgIdx = 3'd4; #1;
        checks++; if (respValidA !== 1'b0 || dbgStateA !== ST_I || cpuReadyA !== 1'b1) begin
            failures++; $display("FAIL stale_done got rv=%b st=%b rdy=%b exp rv=0 st=00 rdy=1", respValidA, dbgStateA, cpuReadyA);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpuValid = 1'b0; cpuOp = RD; cpuIdx = '0;
        busGnt = 1'b0; busDone = 1'b0; busShared = 1'b0;
        snpValid = 1'b0; snpOp = GETS; snpIdx = '0; dbgIdx = '0;
        test_reset();
        test_read_miss_write_hit();
        test_snoop();
        test_upgrade();
        test_evict_race();
        test_ready_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
